stream_fifo: RTL

Byte-stream FIFO inserted between the USB CDC OUT endpoint (`out_data/out_valid/out_ready`) and the UART transmitter's `s_axis` input. It absorbs USB bulk bursts (up to 64 bytes per packet at 12 Mb/s) while the UART drains at 115200 baud. It uses valid/ready handshakes on both sides, first-word-fall-through output, a fill level and an almost-full flag.

---
 rtl/stream_fifo_pkg.sv | 20 ++
 rtl/stream_fifo_ctrl.sv | 84 ++++++++
 rtl/stream_fifo.sv | 75 +++++++
 3 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared constants for the USB<->UART byte-stream FIFOs, plus an elaboration helper.
//   c_FIFO_DATA_WIDTH     : byte width of the stream
//   c_USB2UART_FIFO_DEPTH : capacity of the USB OUT -> UART TX instance
//   c_USB2UART_AFULL      : almost-full threshold of that instance
//   c_UART2USB_FIFO_DEPTH : capacity of the UART RX -> USB IN instance
//   c_UART2USB_AFULL      : almost-full threshold of that instance
package stream_fifo_pkg;

   localparam int unsigned c_FIFO_DATA_WIDTH     = 8;
   localparam int unsigned c_USB2UART_FIFO_DEPTH = 64;
   localparam int unsigned c_USB2UART_AFULL      = 48;
   localparam int unsigned c_UART2USB_FIFO_DEPTH = 64;
   localparam int unsigned c_UART2USB_AFULL      = 48;

   // True for powers of two that are at least 2.
   function automatic bit is_pow2_ge2(input int unsigned v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/stream_fifo_ctrl.sv
// Pointer, level and flag control for stream_fifo; owns no storage so the array can be swapped.
//   clk_i, rst_i      : clock, async active-high reset (already synchronised on deassertion)
//   flush_i           : synchronous clear
//   s_valid_i         : upstream write request
//   m_ready_i         : downstream read acceptance
//   s_ready_c_o       : FIFO can accept a word (combinational)
//   m_valid_c_o       : head word valid (combinational)
//   wr_en_c_o         : a push completes at the coming edge (combinational)
//   wr_ptr_o/rd_ptr_o : storage write / read addresses
//   level_o           : stored word count 0..DEPTH
//   almost_full_o     : level_o >= AFULL_LEVEL
module stream_fifo_ctrl #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned AFULL_LEVEL = 48
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     s_valid_i,
   input  logic                     m_ready_i,
   output logic                     s_ready_c_o,
   output logic                     m_valid_c_o,
   output logic                     wr_en_c_o,
   output logic [$clog2(DEPTH)-1:0] wr_ptr_o,
   output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     almost_full_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          afull_q, afull_d;
   logic          s_ready_c, m_valid_c, push_c, pop_c;

   // Handshake qualification and next-state; flush wins over any handshake.
   always_comb begin
      s_ready_c = (level_q != LW'(DEPTH)) && !flush_i && !rst_i;
      m_valid_c = (level_q != '0) && !flush_i;
      push_c    = s_valid_i && s_ready_c;
      pop_c     = m_valid_c && m_ready_i;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push_c && !pop_c)      level_d = level_q + LW'(1);
         else if (pop_c && !push_c) level_d = level_q - LW'(1);
      end
      // Derived from the next level so the flag lines up with level_o.
      afull_d = (level_d >= LW'(AFULL_LEVEL));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         afull_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         afull_q  <= afull_d;
      end
   end

   assign s_ready_c_o   = s_ready_c;
   assign m_valid_c_o   = m_valid_c;
   assign wr_en_c_o     = push_c;
   assign wr_ptr_o      = wr_ptr_q;
   assign rd_ptr_o      = rd_ptr_q;
   assign level_o       = level_q;
   assign almost_full_o = afull_q;

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through byte-stream FIFO with valid/ready on both sides.
//   clk, rst       : clock, async active-high reset (deassertion synchronised internally)
//   flush          : synchronous clear of pointers and level
//   s_axis_*       : write side (tdata/tvalid in, tready out)
//   m_axis_*       : read side (tdata/tvalid out, tready in); tdata is the head word
//   level          : stored word count 0..DEPTH
//   almost_full    : level >= AFULL_LEVEL
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = c_FIFO_DATA_WIDTH,
   parameter int unsigned DEPTH       = c_USB2UART_FIFO_DEPTH,
   parameter int unsigned AFULL_LEVEL = c_USB2UART_AFULL
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   almost_full
);

   localparam int unsigned AW = $clog2(DEPTH);

   if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
      $error("stream_fifo: DEPTH must be a power of 2 and >= 2");
   end
   if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
      $error("stream_fifo: AFULL_LEVEL must be within 1..DEPTH");
   end

   logic [1:0]            rst_sync_q;
   logic                  rst_int;
   logic                  wr_en_c;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Assert immediately with rst, release two clocks after rst falls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_sync_q <= 2'b11;
      else     rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst_int = rst_sync_q[1];

   stream_fifo_ctrl #(
      .DEPTH       (DEPTH),
      .AFULL_LEVEL (AFULL_LEVEL)
   ) u_ctrl (
      .clk_i         (clk),
      .rst_i         (rst_int),
      .flush_i       (flush),
      .s_valid_i     (s_axis_tvalid),
      .m_ready_i     (m_axis_tready),
      .s_ready_c_o   (s_axis_tready),
      .m_valid_c_o   (m_axis_tvalid),
      .wr_en_c_o     (wr_en_c),
      .wr_ptr_o      (wr_ptr),
      .rd_ptr_o      (rd_ptr),
      .level_o       (level),
      .almost_full_o (almost_full)
   );

   // Storage is intentionally not reset; stale words are never exposed because tvalid gates them.
   always_ff @(posedge clk) begin
      if (wr_en_c) mem_q[wr_ptr] <= s_axis_tdata;
   end

   assign m_axis_tdata = mem_q[rd_ptr];

endmodule
